// File: rtl/router_fsm_pkg.sv
// router_fsm_pkg: shared router FSM state encoding, address constants and port-select helper.
// Contents: state_t (8 controller states), ADDR_INVALID (reserved header address),
//           NUM_PORTS (output port count), port_sel (pick one per-port flag by index).
package router_fsm_pkg;

    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        LOAD_PARITY,
        CHECK_PARITY_ERROR,
        WAIT_TILL_EMPTY
    } state_t;

    localparam logic [1:0] ADDR_INVALID = 2'b11;
    localparam int         NUM_PORTS    = 3;

    // Out-of-range indices read as 0 so an unmapped address can never select a port.
    function automatic logic port_sel(input logic [NUM_PORTS-1:0] v, input int idx);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++)
            if (idx == i) r = v[i];
        return r;
    endfunction

endpackage

// File: rtl/router_fsm.sv
// router_fsm: packet router controller sequencing header decode, payload load, full stalls and parity check.
// Ports: clock/resetn (async active-low); pkt_valid, data_in (header address), fifo_full,
//        fifo_empty_0..2, soft_reset_0..2, parity_done, low_pkt_valid in;
//        detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, busy out
//        (all outputs decoded directly from the current state).
module router_fsm
    import router_fsm_pkg::*;
#(
    parameter int ADDR_W = 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              fifo_empty_0,
    input  logic              fifo_empty_1,
    input  logic              fifo_empty_2,
    input  logic              soft_reset_0,
    input  logic              soft_reset_1,
    input  logic              soft_reset_2,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              write_enb_reg,
    output logic              rst_int_reg,
    output logic              busy
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [NUM_PORTS-1:0] empty_v, soft_v;
    logic                addr_ok;

    assign empty_v = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign soft_v  = {soft_reset_2, soft_reset_1, soft_reset_0};
    assign addr_ok = data_in != ADDR_W'(ADDR_INVALID);

    // addr is captured on every valid DECODE_ADDRESS cycle, even for the reserved address.
    assign addr_d = (state_q == DECODE_ADDRESS && pkt_valid) ? data_in : addr_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            DECODE_ADDRESS:     if (pkt_valid && addr_ok)
                                    state_d = port_sel(empty_v, int'(data_in)) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            LOAD_FIRST_DATA:    state_d = LOAD_DATA;
            LOAD_DATA:          state_d = fifo_full ? FIFO_FULL_STATE : !pkt_valid ? LOAD_PARITY : LOAD_DATA;
            FIFO_FULL_STATE:    state_d = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
            LOAD_AFTER_FULL:    state_d = parity_done ? DECODE_ADDRESS : low_pkt_valid ? LOAD_PARITY : LOAD_DATA;
            LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            WAIT_TILL_EMPTY:    state_d = port_sel(empty_v, int'(addr_q)) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            default:            state_d = DECODE_ADDRESS;
        endcase
        // Only the timeout of the port this packet targets can abort it.
        if (port_sel(soft_v, int'(addr_q))) state_d = DECODE_ADDRESS;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    assign detect_add    = state_q == DECODE_ADDRESS;
    assign lfd_state     = state_q == LOAD_FIRST_DATA;
    assign ld_state      = state_q == LOAD_DATA;
    assign laf_state     = state_q == LOAD_AFTER_FULL;
    assign full_state    = state_q == FIFO_FULL_STATE;
    assign rst_int_reg   = state_q == CHECK_PARITY_ERROR;
    assign write_enb_reg = state_q == LOAD_DATA || state_q == LOAD_PARITY || state_q == LOAD_AFTER_FULL;
    assign busy          = !(state_q == DECODE_ADDRESS || state_q == LOAD_DATA);

endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm: vector table, directed corner sequences and random run against a behavioural model.
module tb_router_fsm;

    localparam int S_DA = 0, S_LFD = 1, S_LD = 2, S_FFS = 3, S_LAF = 4, S_LP = 5, S_CPE = 6, S_WTE = 7;

    typedef struct {
        logic       pv;
        logic [1:0] din;
        logic       ff;
        logic [2:0] fe;
        logic [2:0] sr;
        logic       pd;
        logic       lpv;
        logic [7:0] exp;
    } vec_t;

    logic       clock = 1'b0, resetn = 1'b0, pkt_valid = 1'b0, fifo_full = 1'b0;
    logic [1:0] data_in = 2'd0;
    logic       fifo_empty_0 = 1'b1, fifo_empty_1 = 1'b1, fifo_empty_2 = 1'b1;
    logic       soft_reset_0 = 1'b0, soft_reset_1 = 1'b0, soft_reset_2 = 1'b0;
    logic       parity_done = 1'b0, low_pkt_valid = 1'b0;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, busy;
    logic [7:0] act;
    logic [7:0] otab [8];
    vec_t       tbl[$];
    int         n_cmp = 0, n_err = 0;
    int         ms = S_DA, maddr = 0;

    router_fsm #(.ADDR_W(2)) dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in), .fifo_full(fifo_full),
        .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
        .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
        .full_state(full_state), .write_enb_reg(write_enb_reg), .rst_int_reg(rst_int_reg), .busy(busy)
    );

    assign act = {detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, busy};

    always #5 clock = ~clock;

    task automatic model_reset();
        ms = S_DA;
        maddr = 0;
    endtask

    // Behavioural model: applies the transition rules to the sampled inputs at each rising edge.
    task automatic model_edge();
        bit [3:0] fe4, sr4;
        int nxt;
        fe4 = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
        sr4 = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
        if (!resetn) begin
            model_reset();
            return;
        end
        nxt = ms;
        if (ms == S_DA && pkt_valid && data_in != 2'd3) nxt = fe4[data_in] ? S_LFD : S_WTE;
        if (ms == S_LFD) nxt = S_LD;
        if (ms == S_LD) nxt = fifo_full ? S_FFS : (!pkt_valid ? S_LP : S_LD);
        if (ms == S_FFS && !fifo_full) nxt = S_LAF;
        if (ms == S_LAF) nxt = parity_done ? S_DA : (low_pkt_valid ? S_LP : S_LD);
        if (ms == S_LP) nxt = S_CPE;
        if (ms == S_CPE) nxt = fifo_full ? S_FFS : S_DA;
        if (ms == S_WTE && fe4[maddr]) nxt = S_LFD;
        if (sr4[maddr]) nxt = S_DA;
        if (ms == S_DA && pkt_valid) maddr = int'(data_in);
        ms = nxt;
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: outputs got %b want %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic [1:0] din, input logic ff, input logic [2:0] fe,
                         input logic [2:0] sr, input logic pd, input logic lpv);
        pkt_valid = pv;
        data_in = din;
        fifo_full = ff;
        {fifo_empty_2, fifo_empty_1, fifo_empty_0} = fe;
        {soft_reset_2, soft_reset_1, soft_reset_0} = sr;
        parity_done = pd;
        low_pkt_valid = lpv;
    endtask

    initial begin
        // Output order: detect_add lfd ld laf full write_enb rst_int busy
        otab = '{8'b1000_0000, 8'b0100_0001, 8'b0010_0100, 8'b0000_1001,
                 8'b0001_0101, 8'b0000_0101, 8'b0000_0011, 8'b0000_0001};

        tbl.push_back('{1'b1, 2'd3, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 8'b1000_0000});
        tbl.push_back('{1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 8'b0100_0001});
        tbl.push_back('{1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 8'b0010_0100});
        tbl.push_back('{1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 8'b0010_0100});
        tbl.push_back('{1'b1, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 8'b0000_1001});
        tbl.push_back('{1'b1, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 8'b0000_1001});
        tbl.push_back('{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b1, 8'b0001_0101});
        tbl.push_back('{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b1, 8'b0000_0101});
        tbl.push_back('{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 8'b0000_0011});
        tbl.push_back('{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 8'b1000_0000});
        tbl.push_back('{1'b1, 2'd2, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0, 8'b0000_0001});
        tbl.push_back('{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 8'b0100_0001});
        tbl.push_back('{1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 8'b0010_0100});
        tbl.push_back('{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 8'b0000_0101});
        tbl.push_back('{1'b0, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 8'b0000_0011});
        tbl.push_back('{1'b0, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 8'b0000_1001});
        tbl.push_back('{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 8'b0001_0101});
        tbl.push_back('{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b1, 1'b0, 8'b1000_0000});
        tbl.push_back('{1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 8'b0100_0001});
        tbl.push_back('{1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 8'b0010_0100});
        tbl.push_back('{1'b1, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 8'b0000_1001});
        tbl.push_back('{1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 8'b0001_0101});
        tbl.push_back('{1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 8'b0010_0100});
        tbl.push_back('{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 8'b0000_0101});
        tbl.push_back('{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 8'b0000_0011});
        tbl.push_back('{1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 8'b1000_0000});
        tbl.push_back('{1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 8'b0100_0001});
        tbl.push_back('{1'b1, 2'd1, 1'b0, 3'b111, 3'b001, 1'b0, 1'b0, 8'b0010_0100});
        tbl.push_back('{1'b1, 2'd1, 1'b0, 3'b111, 3'b010, 1'b0, 1'b0, 8'b1000_0000});

        // Reset state, both before and across a clock edge
        #2 chk("reset_async", 8'b1000_0000);
        step();
        chk("reset_hold", 8'b1000_0000);
        resetn = 1'b1;

        // First packet straight after reset: DECODE, LFD, LOAD_DATA with write enable
        drive(1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
        chk("first_decode", 8'b1000_0000);
        step();
        chk("first_lfd", 8'b0100_0001);
        step();
        chk("first_ld_wen", 8'b0010_0100);
        drive(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
        step();
        chk("first_parity", 8'b0000_0101);
        step();
        chk("first_check", 8'b0000_0011);
        step();
        chk("first_done", 8'b1000_0000);

        foreach (tbl[i]) begin
            drive(tbl[i].pv, tbl[i].din, tbl[i].ff, tbl[i].fe, tbl[i].sr, tbl[i].pd, tbl[i].lpv);
            step();
            chk($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Port 2 busy for five cycles, then drains
        drive(1'b1, 2'd2, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0);
        step();
        chk("wait_0", 8'b0000_0001);
        drive(1'b0, 2'd0, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0);
        for (int i = 1; i < 5; i++) begin
            step();
            chk($sformatf("wait_%0d", i), 8'b0000_0001);
        end
        drive(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
        step();
        chk("wait_exit_lfd", 8'b0100_0001);
        repeat (4) begin
            step();
            chk("wait_tail", otab[ms]);
        end
        chk("wait_tail_idle", 8'b1000_0000);

        // Soft reset only honoured for the latched port
        drive(1'b1, 2'd0, 1'b0, 3'b110, 3'b000, 1'b0, 1'b0);
        step();
        chk("sr_wait", 8'b0000_0001);
        drive(1'b0, 2'd0, 1'b0, 3'b110, 3'b010, 1'b0, 1'b0);
        step();
        chk("sr_other_ignored", 8'b0000_0001);
        drive(1'b0, 2'd0, 1'b0, 3'b110, 3'b001, 1'b0, 1'b0);
        step();
        chk("sr_own_aborts", 8'b1000_0000);

        // Asynchronous reset mid-payload
        drive(1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
        step();
        step();
        chk("mid_ld", 8'b0010_0100);
        #2 resetn = 1'b0;
        model_reset();
        #1 chk("mid_reset_async", 8'b1000_0000);
        step();
        chk("mid_reset_no_wen", 8'b1000_0000);
        resetn = 1'b1;

        // Random traffic against the behavioural model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 150) == 0) begin
                resetn = 1'b0;
                model_reset();
            end else begin
                resetn = 1'b1;
            end
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
                  3'($urandom), {$urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0},
                  $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
            step();
            chk($sformatf("rand%0d", i), otab[ms]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/router_fsm.md
ROUTER_FSM -- requirements
Module: router_fsm

Interface
REQ-001 SHALL have parameter ADDR_W, default 2, meaning the width of the destination address field in the header byte.
REQ-002 SHALL have port clock, input, 1, the single rising-edge clock.
REQ-003 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port pkt_valid, input, 1, meaning a packet byte is present on the input bus.
REQ-005 SHALL have port data_in, input, ADDR_W, the header address bits [1:0]; 2'b11 is invalid.
REQ-006 SHALL have port fifo_full, input, 1, meaning the selected output FIFO is full.
REQ-007 SHALL have ports fifo_empty_0/1/2, inputs, 1 each, per-port FIFO empty.
REQ-008 SHALL have ports soft_reset_0/1/2, inputs, 1 each, per-port timeout soft reset.
REQ-009 SHALL have ports parity_done and low_pkt_valid, inputs, 1 each, from the register block.
REQ-010 SHALL have ports detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, busy, outputs, 1 each.

Function
REQ-011 SHALL implement 8 states: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
REQ-012 SHALL latch data_in into an internal addr register on the clock edge where state is DECODE_ADDRESS and pkt_valid=1.
REQ-013 DECODE_ADDRESS: pkt_valid=1, data_in!=3, fifo_empty[data_in]=1 -> LOAD_FIRST_DATA; pkt_valid=1, data_in!=3, fifo_empty[data_in]=0 -> WAIT_TILL_EMPTY; otherwise stay; data_in=3 is always ignored.
REQ-014 LOAD_FIRST_DATA SHALL go to LOAD_DATA unconditionally after one cycle.
REQ-015 LOAD_DATA: fifo_full=1 -> FIFO_FULL_STATE; else pkt_valid=0 -> LOAD_PARITY; else stay.
REQ-016 FIFO_FULL_STATE: fifo_full=0 -> LOAD_AFTER_FULL; else stay.
REQ-017 LOAD_AFTER_FULL: parity_done=1 -> DECODE_ADDRESS; else low_pkt_valid=1 -> LOAD_PARITY; else LOAD_DATA.
REQ-018 LOAD_PARITY SHALL go to CHECK_PARITY_ERROR unconditionally.
REQ-019 CHECK_PARITY_ERROR: fifo_full=1 -> FIFO_FULL_STATE; else DECODE_ADDRESS.
REQ-020 WAIT_TILL_EMPTY: fifo_empty[addr]=1 -> LOAD_FIRST_DATA; else stay.
REQ-021 soft_reset_N=1 with addr=N SHALL force the next state to DECODE_ADDRESS from any state, overriding REQ-013..REQ-020; soft resets for other ports are ignored.
REQ-022 Outputs SHALL be Moore decodes of the current state: detect_add=DECODE_ADDRESS, lfd_state=LOAD_FIRST_DATA, ld_state=LOAD_DATA, laf_state=LOAD_AFTER_FULL, full_state=FIFO_FULL_STATE, rst_int_reg=CHECK_PARITY_ERROR.
REQ-023 write_enb_reg SHALL be 1 in LOAD_DATA, LOAD_PARITY and LOAD_AFTER_FULL only.
REQ-024 busy SHALL be 0 in DECODE_ADDRESS and LOAD_DATA and 1 in all other states.
REQ-025 The latency from a state change to the output change SHALL be 0 cycles, with no output registering.

Reset
REQ-026 resetn=0 SHALL asynchronously set state=DECODE_ADDRESS and addr=0.
REQ-027 During reset, outputs SHALL be detect_add=1 and all other outputs 0.
REQ-028 Reset asserted mid-packet SHALL abandon the packet with no further write_enb_reg pulse.

Structure
REQ-029 The state encoding, the invalid address constant 2'b11 and the port count 3 SHALL live in the shared router package.
REQ-030 The block SHALL be a single module; no sub-module is required.

Verification
REQ-031 Bench SHALL cover: reset, then pkt_valid=1, data_in=01, fifo_empty_1=1 -> DECODE, LFD, LOAD_DATA on consecutive cycles, with write_enb_reg=1 from the LOAD_DATA cycle.
REQ-032 Bench SHALL cover: data_in=11 with pkt_valid=1 -> state stays DECODE_ADDRESS and busy stays 0.
REQ-033 Bench SHALL cover: data_in=10, fifo_empty_2=0 for 5 cycles, then 1 -> WAIT_TILL_EMPTY for 5 cycles, then LOAD_FIRST_DATA with busy=1 throughout.
REQ-034 Bench SHALL cover: fifo_full=1 in LOAD_DATA -> full_state=1, write_enb_reg=0; then fifo_full=0 and low_pkt_valid=1 -> LAF, LOAD_PARITY, CHECK_PARITY_ERROR with rst_int_reg=1, then DECODE_ADDRESS.
REQ-035 Bench SHALL cover: addr=00 in WAIT_TILL_EMPTY with soft_reset_1=1 -> no change; soft_reset_0=1 -> DECODE_ADDRESS next cycle.
REQ-036 Bench SHALL cover: resetn pulsed low mid-LOAD_DATA -> detect_add=1 immediately, without waiting for a clock edge.
